// File: rtl/fib_share_arb_pkg.sv
// Shared definitions for the two-requester Fibonacci-unit sequencer.
package fib_share_arb_pkg;

  localparam int unsigned W_I_DEF = 5;
  localparam int unsigned W_F_DEF = 20;

  typedef enum logic [1:0] {
    s_idle  = 2'b00,
    s_start = 2'b01,
    s_wait  = 2'b10
  } state_t;

endpackage

// File: rtl/fib_share_arb_if.sv
// Requester and shared-unit signals of fib_share_arb.
interface fib_share_arb_if
  import fib_share_arb_pkg::*;
#(
  parameter int unsigned W_I = W_I_DEF,
  parameter int unsigned W_F = W_F_DEF
);

  logic           req0;
  logic [W_I-1:0] i0;
  logic           req1;
  logic [W_I-1:0] i1;
  logic           ack0;
  logic           ack1;
  logic           done0;
  logic           done1;
  logic [W_F-1:0] f0;
  logic [W_F-1:0] f1;
  logic           busy;
  logic           fib_start;
  logic [W_I-1:0] fib_i;
  logic           fib_done_tick;
  logic [W_F-1:0] fib_f;

  // Arbiter side
  modport slave (
    input  req0, i0, req1, i1, fib_done_tick, fib_f,
    output ack0, ack1, done0, done1, f0, f1, busy, fib_start, fib_i
  );

  // Requesters plus shared unit side
  modport master (
    output req0, i0, req1, i1, fib_done_tick, fib_f,
    input  ack0, ack1, done0, done1, f0, f1, busy, fib_start, fib_i
  );

endinterface

// File: rtl/fib_share_arb_rr_arb2.sv
// Combinational two-way round-robin grant; prio names the winner on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       any
);

  assign gnt[0] = req[0] & (~req[1] | ~prio);
  assign gnt[1] = req[1] & (~req[0] |  prio);
  assign any    = |req;

endmodule

// File: rtl/fib_share_arb.sv
// Round-robin sequencer sharing one Fibonacci unit between two requesters.
module fib_share_arb
  import fib_share_arb_pkg::*;
#(
  parameter int unsigned W_I = W_I_DEF,
  parameter int unsigned W_F = W_F_DEF
) (
  input  logic            clk,
  input  logic            reset,
  fib_share_arb_if.slave  bus
);

  state_t         state_reg, state_next;
  logic           owner_reg, owner_next;
  logic           prio_reg,  prio_next;
  logic [W_I-1:0] i_reg,     i_next;
  logic [W_F-1:0] f0_reg,    f0_next;
  logic [W_F-1:0] f1_reg,    f1_next;
  logic           ack0_reg,  ack0_next;
  logic           ack1_reg,  ack1_next;
  logic           done0_reg, done0_next;
  logic           done1_reg, done1_next;

  logic [1:0]     gnt;
  logic           any;

  rr_arb2 u_arb (
    .req  ({bus.req1, bus.req0}),
    .prio (prio_reg),
    .gnt  (gnt),
    .any  (any)
  );

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= s_idle;
      owner_reg <= 1'b0;
      prio_reg  <= 1'b0;
      i_reg     <= '0;
      f0_reg    <= '0;
      f1_reg    <= '0;
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      prio_reg  <= prio_next;
      i_reg     <= i_next;
      f0_reg    <= f0_next;
      f1_reg    <= f1_next;
      ack0_reg  <= ack0_next;
      ack1_reg  <= ack1_next;
      done0_reg <= done0_next;
      done1_reg <= done1_next;
    end
  end

  // Next-state and register updates; pulses default low
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    prio_next  = prio_reg;
    i_next     = i_reg;
    f0_next    = f0_reg;
    f1_next    = f1_reg;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    done0_next = 1'b0;
    done1_next = 1'b0;

    case (state_reg)
      s_idle: begin
        if (any) begin
          owner_next = gnt[1];
          i_next     = gnt[1] ? bus.i1 : bus.i0;
          ack0_next  = gnt[0];
          ack1_next  = gnt[1];
          state_next = s_start;
        end
      end
      s_start: begin
        state_next = s_wait;
      end
      s_wait: begin
        // Priority flips only on completion so a grant never moves it
        if (bus.fib_done_tick) begin
          if (owner_reg) begin
            f1_next    = bus.fib_f;
            done1_next = 1'b1;
          end else begin
            f0_next    = bus.fib_f;
            done0_next = 1'b1;
          end
          prio_next  = ~owner_reg;
          state_next = s_idle;
        end
      end
      default: begin
        state_next = s_idle;
      end
    endcase
  end

  assign bus.ack0      = ack0_reg;
  assign bus.ack1      = ack1_reg;
  assign bus.done0     = done0_reg;
  assign bus.done1     = done1_reg;
  assign bus.f0        = f0_reg;
  assign bus.f1        = f1_reg;
  assign bus.busy      = (state_reg != s_idle);
  assign bus.fib_start = (state_reg == s_start);
  assign bus.fib_i     = i_reg;

endmodule

// File: tb/tb_fib_share_arb.sv
// Self-checking bench for fib_share_arb with a latency-configurable Fibonacci unit model.
module tb_fib_share_arb;
  import fib_share_arb_pkg::*;

  localparam int unsigned W_I = W_I_DEF;
  localparam int unsigned W_F = W_F_DEF;
  localparam int SIG_ACK0 = 0, SIG_ACK1 = 1, SIG_DONE0 = 2, SIG_DONE1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fib_share_arb_if #(.W_I(W_I), .W_F(W_F)) bus ();

  fib_share_arb #(.W_I(W_I), .W_F(W_F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [W_F-1:0] fib(input int unsigned n);
    int unsigned a = 0, b = 1, t;
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return W_F'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Shared Fibonacci unit: answers fib(i) 'lat' cycles after fib_start
  int          lat = 3;
  bit          spur_req = 1'b0;
  int          spur_fired = 0;
  int          real_ticks = 0;
  int unsigned real_tick_cyc = 0;
  bit          m_active = 1'b0;
  int          m_cnt = 0;
  logic [W_I-1:0] m_i = '0;

  initial begin
    bus.fib_done_tick = 1'b0;
    bus.fib_f = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.fib_done_tick = 1'b0;
      if (reset) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          bus.fib_done_tick = 1'b1;
          bus.fib_f = fib(int'(m_i));
          m_active = 1'b0;
          real_tick_cyc = cyc_cnt;
          real_ticks++;
        end
      end else if (bus.fib_start) begin
        m_active = 1'b1;
        m_i = bus.fib_i;
        m_cnt = lat;
      end
      // Spurious ticks only while the arbiter is idle or starting
      if (spur_req && !bus.fib_done_tick && (!bus.busy || bus.fib_start)) begin
        bus.fib_done_tick = 1'b1;
        bus.fib_f = W_F'($urandom);
        spur_fired++;
      end
      spur_req = 1'b0;
    end
  end

  bit          hold0 = 1'b0, hold1 = 1'b0;
  bit          prev_busy = 1'b0;
  int          ack_bad = 0;
  int          order_q[$];
  int unsigned start_q[$];

  // One clock; log grants, drop non-held requests once acknowledged
  task automatic step();
    prev_busy = bus.busy;
    @(posedge clk);
    #1;
    if (bus.ack0) order_q.push_back(0);
    if (bus.ack1) order_q.push_back(1);
    if (bus.fib_start) start_q.push_back(cyc_cnt);
    if ((bus.ack0 | bus.ack1) && prev_busy) ack_bad++;
    if (((bus.ack0 | bus.ack1) != bus.fib_start) || (bus.ack0 & bus.ack1)) ack_bad++;
    if (bus.ack0 && !hold0) bus.req0 = 1'b0;
    if (bus.ack1 && !hold1) bus.req1 = 1'b0;
  endtask

  function automatic logic sig(input int w);
    case (w)
      SIG_ACK0:  return bus.ack0;
      SIG_ACK1:  return bus.ack1;
      SIG_DONE0: return bus.done0;
      default:   return bus.done1;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sig(w) && n < budget);
    check(tag, 32'(sig(w)), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    hold0 = 1'b0;
    hold1 = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  int          n;
  int          t1;
  int          bad;
  bit          changed;
  bit          exp_prio, owner, exp_ack, w;
  bit [1:0]    req_prev;
  logic [W_I-1:0] ip0, ip1;
  logic [W_I-1:0] cap_i [2];
  logic [W_F-1:0] exp_f [2];
  int          last_rt;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.i0 = '0; bus.i1 = '0;

    // Reset with random inputs
    reset = 1'b1;
    bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
    bus.i0 = W_I'($urandom); bus.i1 = W_I'($urandom);
    repeat (3) step();
    check("rst_ack0", 32'(bus.ack0), 0);
    check("rst_ack1", 32'(bus.ack1), 0);
    check("rst_done0", 32'(bus.done0), 0);
    check("rst_done1", 32'(bus.done1), 0);
    check("rst_f0", 32'(bus.f0), 0);
    check("rst_f1", 32'(bus.f1), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_start", 32'(bus.fib_start), 0);
    check("rst_fib_i", 32'(bus.fib_i), 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    reset = 1'b0;
    changed = 1'b0;
    repeat (20) begin
      step();
      if (bus.ack0 | bus.ack1 | bus.done0 | bus.done1 | bus.busy | bus.fib_start |
          (bus.f0 != 0) | (bus.f1 != 0) | (bus.fib_i != 0)) changed = 1'b1;
    end
    check("idle_quiet", 32'(changed), 0);

    // Single request from requester 0
    lat = 3;
    bus.i0 = W_I'(10); bus.req0 = 1'b1;
    step();
    check("single_ack0", 32'(bus.ack0), 1);
    check("single_ack1", 32'(bus.ack1), 0);
    check("single_start", 32'(bus.fib_start), 1);
    check("single_fib_i", 32'(bus.fib_i), 10);
    check("single_busy", 32'(bus.busy), 1);
    wait_for("single_done0", SIG_DONE0, 100, n);
    check("single_latency", 32'(n), 32'(lat + 1));
    check("single_f0", 32'(bus.f0), 55);
    check("single_f1", 32'(bus.f1), 0);
    check("single_busy_fall", 32'(bus.busy), 0);
    check("single_no_done1", 32'(bus.done1), 0);
    step();
    check("single_done_pulse", 32'(bus.done0), 0);
    check("single_f0_held", 32'(bus.f0), 55);

    // Simultaneous requests after reset
    do_reset();
    lat = 30;
    order_q.delete(); start_q.delete();
    bus.i0 = W_I'(5); bus.i1 = W_I'(7);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_for("sim_done0", SIG_DONE0, 200, n);
    check("sim_f0", 32'(bus.f0), 5);
    t1 = int'(real_tick_cyc);
    wait_for("sim_done1", SIG_DONE1, 200, n);
    check("sim_f1", 32'(bus.f1), 13);
    check("sim_f0_kept", 32'(bus.f0), 5);
    check("sim_grants", 32'(order_q.size()), 2);
    check("sim_first", 32'((order_q.size() >= 1) ? order_q[0] : -1), 0);
    check("sim_second", 32'((order_q.size() >= 2) ? order_q[1] : -1), 1);
    check("sim_restart_gap", 32'((start_q.size() >= 2) ? int'(start_q[1]) - t1 : -1), 2);

    // Continuous requests from both sides alternate
    do_reset();
    lat = 3;
    order_q.delete();
    hold0 = 1'b1; hold1 = 1'b1;
    bus.i0 = W_I'(20); bus.i1 = W_I'(3);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        wait_for("rr_done0", SIG_DONE0, 100, n);
        check("rr_f0", 32'(bus.f0), 6765);
      end else begin
        wait_for("rr_done1", SIG_DONE1, 100, n);
        check("rr_f1", 32'(bus.f1), 2);
      end
    end
    bad = (order_q.size() >= 6) ? 0 : 1;
    for (int j = 0; j < 6 && j < order_q.size(); j++)
      if (order_q[j] != j % 2) bad++;
    check("rr_order", 32'(bad), 0);
    check("rr_ack_rules", 32'(ack_bad), 0);

    // Spurious completion ticks in idle and in start
    do_reset();
    lat = 5;
    spur_fired = 0;
    spur_req = 1'b1;
    step();
    check("spur_idle_done0", 32'(bus.done0), 0);
    check("spur_idle_done1", 32'(bus.done1), 0);
    check("spur_idle_busy", 32'(bus.busy), 0);
    check("spur_idle_f0", 32'(bus.f0), 0);
    bus.i0 = W_I'(6); bus.req0 = 1'b1;
    step();
    check("spur_ack0", 32'(bus.ack0), 1);
    spur_req = 1'b1;
    step();
    check("spur_start_done0", 32'(bus.done0), 0);
    check("spur_start_busy", 32'(bus.busy), 1);
    check("spur_start_f0", 32'(bus.f0), 0);
    check("spur_start_f1", 32'(bus.f1), 0);
    check("spur_fired", 32'(spur_fired), 2);
    wait_for("spur_done0", SIG_DONE0, 100, n);
    check("spur_f0", 32'(bus.f0), 8);

    // Reset while requester 1 is being served (priority currently favours 1)
    lat = 30;
    bus.i1 = W_I'(9); bus.req1 = 1'b1;
    wait_for("mid_ack1", SIG_ACK1, 20, n);
    repeat (5) step();
    check("mid_waiting", 32'(bus.busy), 1);
    reset = 1'b1;
    step();
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_f0", 32'(bus.f0), 0);
    check("mid_f1", 32'(bus.f1), 0);
    check("mid_start", 32'(bus.fib_start), 0);
    check("mid_fib_i", 32'(bus.fib_i), 0);
    reset = 1'b0;
    changed = 1'b0;
    repeat (40) begin
      step();
      if (bus.done0 | bus.done1) changed = 1'b1;
    end
    check("mid_no_stale_done", 32'(changed), 0);
    bus.i0 = W_I'(2); bus.i1 = W_I'(12);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_for("mid_prio_ack0", SIG_ACK0, 3, n);
    wait_for("mid_done0", SIG_DONE0, 100, n);
    check("mid_f0_new", 32'(bus.f0), 1);
    wait_for("mid_done1", SIG_DONE1, 100, n);
    check("mid_f1_new", 32'(bus.f1), 144);

    // Randomized traffic against a grant/result scoreboard
    do_reset();
    exp_prio = 1'b0; owner = 1'b0;
    exp_f[0] = '0; exp_f[1] = '0;
    cap_i[0] = '0; cap_i[1] = '0;
    last_rt = real_ticks;
    for (int c = 0; c < 1500; c++) begin
      req_prev = {bus.req1, bus.req0};
      ip0 = bus.i0; ip1 = bus.i1;
      step();
      exp_ack = !prev_busy && (req_prev != 2'b00);
      check("rand_ack", 32'(bus.ack0 | bus.ack1), 32'(exp_ack));
      if (exp_ack) begin
        w = (req_prev == 2'b11) ? exp_prio : req_prev[1];
        check("rand_winner", 32'(bus.ack1), 32'(w));
        owner = w;
        cap_i[w] = w ? ip1 : ip0;
      end
      check("rand_done", 32'(bus.done0 | bus.done1), 32'(real_ticks != last_rt));
      if (real_ticks != last_rt) begin
        check("rand_done_owner", 32'(bus.done1), 32'(owner));
        exp_f[owner] = fib(int'(cap_i[owner]));
        exp_prio = ~owner;
      end
      last_rt = real_ticks;
      check("rand_f0", 32'(bus.f0), 32'(exp_f[0]));
      check("rand_f1", 32'(bus.f1), 32'(exp_f[1]));
      if (!bus.req0 && ($urandom % 4 == 0)) begin
        bus.req0 = 1'b1; bus.i0 = W_I'($urandom);
      end else if (bus.req0 && !bus.ack0 && ($urandom % 16 == 0)) begin
        bus.req0 = 1'b0;
      end
      if (!bus.req1 && ($urandom % 4 == 0)) begin
        bus.req1 = 1'b1; bus.i1 = W_I'($urandom);
      end else if (bus.req1 && !bus.ack1 && ($urandom % 16 == 0)) begin
        bus.req1 = 1'b0;
      end
      lat = int'($urandom_range(1, 12));
      spur_req = ($urandom % 8 == 0);
    end
    check("final_ack_rules", 32'(ack_bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_share_arb.md
Name: fib_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one shared Fibonacci unit (start/i/done_tick/f interface).
- Latches the winner's index, starts the unit, waits for completion, then returns the result into a per-requester register with a done pulse.
- Lets two client FSMs, e.g. two BCD front ends, share one fib datapath without contention.

Parameters:
- W_I, 5, width of the Fibonacci index
- W_F, 20, width of the Fibonacci result

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0  in  1  request level from requester 0; sampled only in s_idle
- i0  in  W_I  index from requester 0; valid while req0=1
- req1  in  1  request level from requester 1
- i1  in  W_I  index from requester 1
- ack0  out  1  one-cycle pulse: request 0 accepted, i0 captured
- ack1  out  1  one-cycle pulse: request 1 accepted, i1 captured
- done0  out  1  one-cycle pulse: f0 updated
- done1  out  1  one-cycle pulse: f1 updated
- f0  out  W_F  last result for requester 0; held until its next completion
- f1  out  W_F  last result for requester 1
- busy  out  1  1 whenever state != s_idle
- fib_start  out  1  start pulse to the shared unit
- fib_i  out  W_I  index to the shared unit; driven from i_reg
- fib_done_tick  in  1  completion pulse from the shared unit
- fib_f  in  W_F  result from the shared unit; valid with fib_done_tick

Behaviour:
- Registers: state_reg, owner_reg (1b), prio_reg (1b), i_reg, f0_reg, f1_reg, ack0/1_reg, done0/1_reg. All outputs come directly from registers or the state; there are no combinational input-to-output paths.
- Reset values: state=s_idle, owner=0, prio=0, i_reg=0, f0=f1=0, all pulses=0, busy=0, fib_start=0, fib_i=0.
- States are s_idle, s_start and s_wait, with 2-bit encoding; unused codes go to s_idle.
- s_idle, arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the requester equal to prio_reg wins.
  - On a win: i_reg<=i_winner, owner<=winner, ack_winner_reg<=1, next state s_start.
  - No req: stay.
- s_start: fib_start=1 for exactly this cycle; next state s_wait unconditionally.
- s_wait: on fib_done_tick:
  - f_owner<=fib_f and done_owner_reg<=1.
  - prio<=~owner.
  - next state s_idle.
  - Otherwise stay.
- Latency:
  - req seen in idle cycle T gives ack and fib_start in cycle T+1.
  - fib_done_tick in cycle D gives done_k and the new f_k in cycle D+1.
  - Arbitration may occur again in cycle D+1, so back-to-back service is possible.
- Handshake:
  - Requester holds req and i stable until it sees ack.
  - req still high in an idle cycle after completion counts as a new request.
  - Dropping req before ack withdraws the request with no side effects.
- Fairness: continuous requests from both sides alternate strictly 0,1,0,1,...
- prio_reg changes only on completion, never on grant.
- fib_done_tick in s_idle or s_start is ignored: no done, no f update, no state change.
- f_k of the non-owner never changes.
- Reset mid-operation (any state) returns all registers to their reset values immediately. The shared unit shares the reset, so no stale completion is credited.
- Result width: fib_f is copied unmodified. Overflow and index-range checks remain the clients' responsibility.

Decomposition:
- Shared package holds:
  - the state localparams s_idle=2'b00, s_start=2'b01, s_wait=2'b10;
  - the W_I and W_F defaults.
- One natural sub-module, rr_arb2: combinational 2-way round-robin grant.
  - Inputs: req[1:0], prio.
  - Outputs: gnt[1:0] one-hot, any.
- The FSM and result registers stay in fib_share_arb.

Test Plan (bench uses a behavioural fib model with configurable latency, e.g. 3 and 30 cycles):
- Reset: assert reset with random inputs -> all outputs 0 and busy=0; release, idle with no req -> nothing changes for 20 cycles.
- Single request, req0=1, i0=10, dropped after ack:
  - ack0 and fib_start=1 with fib_i=10 exactly one cycle after the req cycle;
  - model returns 55 -> done0 one cycle after fib_done_tick, f0=55, f1 stays 0, busy falls with done0.
- Simultaneous requests after reset (i0=5, i1=7, both held until their ack):
  - requester 0 served first, f0=5/done0;
  - then requester 1, f1=13/done1;
  - the second fib_start occurs 2 cycles after the first completion.
- Both req held continuously for 6 completions with i0=20, i1=3 -> grant order 0,1,0,1,0,1; f0=6765 and f1=2 after each respective done; no ack while busy.
- Spurious fib_done_tick pulsed in s_idle and in s_start -> no done0/done1, f registers unchanged, sequence completes normally on the real tick.
- Reset asserted in s_wait while owner=1 -> state s_idle, prio=0, f1 unchanged from reset value 0; after release req1 with i1=12 -> f1=144 and done1.
